coin_change_dispenser: RTL and testbench

//  Downstream stage of the vending-machine FSM. It takes the change amount (in cents) owed

---
 rtl/coin_change_dispenser.sv | 149 ++++++++++++++
 tb/tb_coin_change_dispenser.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_change_dispenser.sv
// ============================================================================
// Module   : coin_change_dispenser
// Function : Greedy coin payout (dollar/quarter/dime) over a 4-phase req/ack
//            ejector handshake, with residue, coin count and timeout fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_change_dispenser #(
  parameter int AMT_W       = 10,
  parameter int CNT_W       = 5,
  parameter int DOLLAR_VAL  = 100,
  parameter int QUARTER_VAL = 25,
  parameter int DIME_VAL    = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  output logic             coin_dollar,
  output logic             coin_quarter,
  output logic             coin_dime,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] residue,
  output logic [CNT_W-1:0] coin_cnt,
  output logic             fault
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [AMT_W-1:0] C_DOLLAR  = AMT_W'(DOLLAR_VAL);
  localparam logic [AMT_W-1:0] C_QUARTER = AMT_W'(QUARTER_VAL);
  localparam logic [AMT_W-1:0] C_DIME    = AMT_W'(DIME_VAL);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_EJECT = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] residue_q, residue_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q, fault_d;
  // One-hot selected coin: {dime, quarter, dollar}
  logic [2:0]       coin_q, coin_d;
  logic [AMT_W-1:0] w_coin_val;

  always_comb begin
    if (coin_q[0])      w_coin_val = C_DOLLAR;
    else if (coin_q[1]) w_coin_val = C_QUARTER;
    else                w_coin_val = C_DIME;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    residue_d   = residue_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    fault_d     = fault_q;
    coin_d      = coin_q;
    case (state_q)
      S_IDLE: begin
        if (chg_valid) begin
          remaining_d = chg_amt;
          cnt_d       = '0;
          residue_d   = '0;
          fault_d     = 1'b0;
          state_d     = S_SEL;
        end
      end
      S_SEL: begin
        if (remaining_q >= C_DOLLAR) begin
          coin_d  = 3'b001;
          state_d = S_EJECT;
        end else if (remaining_q >= C_QUARTER) begin
          coin_d  = 3'b010;
          state_d = S_EJECT;
        end else if (remaining_q >= C_DIME) begin
          coin_d  = 3'b100;
          state_d = S_EJECT;
        end else begin
          // Residue is loaded on entry so it is already valid alongside done.
          residue_d = remaining_q;
          state_d   = S_DONE;
        end
      end
      S_EJECT: begin
        if (coin_ack) begin
          remaining_d = remaining_q - w_coin_val;
          cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d     = S_REL;
        end else if (tmo_q == TMO_LAST) begin
          fault_d   = 1'b1;
          residue_d = remaining_q;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_REL: begin
        if (!coin_ack) state_d = S_SEL;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      residue_q   <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      fault_q     <= 1'b0;
      coin_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residue_q   <= residue_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      fault_q     <= fault_d;
      coin_q      <= coin_d;
    end
  end

  assign chg_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign coin_dollar  = (state_q == S_EJECT) && coin_q[0];
  assign coin_quarter = (state_q == S_EJECT) && coin_q[1];
  assign coin_dime    = (state_q == S_EJECT) && coin_q[2];
  assign residue      = residue_q;
  assign coin_cnt     = cnt_q;
  assign fault        = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_coin_change_dispenser.sv
// ============================================================================
// Module   : tb_coin_change_dispenser
// Function : Self-checking bench for coin_change_dispenser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coin_change_dispenser;

  localparam int AMT_W = 10;
  localparam int CNT_W = 5;
  localparam int TMO   = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             chg_valid;
  logic [AMT_W-1:0] chg_amt;
  logic             chg_ready;
  logic             coin_dollar, coin_quarter, coin_dime;
  logic             coin_ack;
  logic             busy, done, fault;
  logic [AMT_W-1:0] residue;
  logic [CNT_W-1:0] coin_cnt;

  int errors = 0;
  int checks = 0;
  int exp_coins[$];

  coin_change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .DOLLAR_VAL(100), .QUARTER_VAL(25),
    .DIME_VAL(10), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .chg_valid(chg_valid), .chg_amt(chg_amt),
    .chg_ready(chg_ready), .coin_dollar(coin_dollar), .coin_quarter(coin_quarter),
    .coin_dime(coin_dime), .coin_ack(coin_ack), .busy(busy), .done(done),
    .residue(residue), .coin_cnt(coin_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amt; int d; int h; int stuck;
    int cnt; int res; int flt; int dcyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy payout from plain arithmetic; a stuck ejector faults on the first coin.
  task automatic model(input int amt, input int d, input int h, input int stuck,
                       output int cnt, output int res, output int flt, output int dcyc);
    int r;
    int first;
    r = amt;
    exp_coins.delete();
    while (r >= 10) begin
      if (r >= 100)     begin exp_coins.push_back(0); r -= 100; end
      else if (r >= 25) begin exp_coins.push_back(1); r -= 25;  end
      else              begin exp_coins.push_back(2); r -= 10;  end
    end
    if (stuck != 0 && exp_coins.size() > 0) begin
      first = exp_coins[0];
      exp_coins.delete();
      exp_coins.push_back(first);
      cnt = 0; res = amt; flt = 1; dcyc = 2 + TMO;
    end else begin
      cnt = exp_coins.size(); res = r; flt = 0;
      dcyc = 2 + cnt * (d + h + 3);
    end
  endtask

  task automatic start_payout(input int amt, input string tag);
    @(posedge clk); #1;
    check({tag, " ready_before"}, {31'd0, chg_ready}, 32'd1);
    check({tag, " done_clear"}, {31'd0, done}, 32'd0);
    chg_valid = 1'b1;
    chg_amt   = AMT_W'(amt);
    @(posedge clk); #1;
    chg_valid = 1'b0;
  endtask

  // Called at cycle 1 after the accept edge; plays the ejector and checks the payout.
  task automatic run_payout(input int d, input int h, input int stuck, input bit jitter,
                            input int ecnt, input int eres, input int eflt, input int edone,
                            input string tag);
    int  got[$];
    int  starts[$];
    int  cyc = 1;
    int  age = 0;
    int  rel = 0;
    int  ncoin;
    bit  prev_req = 0;
    bit  onehot_ok = 1;
    bit  busy_ok = 1;
    bit  seen_done = 0;
    coin_ack = 1'b0;
    while (cyc < 3000 && !seen_done) begin
      ncoin = int'(coin_dollar) + int'(coin_quarter) + int'(coin_dime);
      if (ncoin > 1) onehot_ok = 0;
      if (!busy || chg_ready) busy_ok = 0;
      if (done) begin
        seen_done = 1;
        check({tag, " done_cycle"}, cyc, edone);
        check({tag, " residue"}, {22'd0, residue}, eres);
        check({tag, " coin_cnt"}, {27'd0, coin_cnt}, ecnt);
        check({tag, " fault"}, {31'd0, fault}, eflt);
      end else begin
        if (ncoin == 1) begin
          if (!prev_req) begin
            got.push_back(coin_dollar ? 0 : (coin_quarter ? 1 : 2));
            starts.push_back(cyc);
            age = 0;
          end else begin
            age++;
          end
          if (stuck == 0 && age >= d) coin_ack = 1'b1;
          prev_req = 1;
        end else begin
          prev_req = 0;
          if (coin_ack) begin
            if (rel >= h) begin coin_ack = 1'b0; rel = 0; end
            else rel++;
          end
        end
        if (jitter) chg_amt = AMT_W'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
    end
    coin_ack = 1'b0;
    if (!seen_done) begin
      errors++; checks++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, cyc);
    end
    check({tag, " onehot"}, {31'd0, onehot_ok}, 32'd1);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " n_coins"}, got.size(), exp_coins.size());
    for (int i = 0; i < got.size() && i < exp_coins.size(); i++) begin
      check($sformatf("%s coin%0d", tag, i), got[i], exp_coins[i]);
      check($sformatf("%s start%0d", tag, i), starts[i], 2 + i * (d + h + 3));
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   mc, mr, mf, md;
    int   amt, d, h, stuck;
    bit   found, no_done;

    tbl[0] = '{135, 2, 0, 0, 3, 0,  0, 17};
    tbl[1] = '{5,   1, 0, 0, 0, 5,  0, 2};
    tbl[2] = '{60,  0, 0, 1, 0, 60, 1, 2 + TMO};
    tbl[3] = '{0,   0, 0, 0, 0, 0,  0, 2};
    tbl[4] = '{20,  1, 5, 0, 2, 0,  0, 20};
    tbl[5] = '{1023,0, 0, 0, 12,3,  0, 38};
    tbl[6] = '{99,  0, 1, 0, 5, 4,  0, 22};
    tbl[7] = '{9,   0, 0, 1, 0, 9,  0, 2};

    rst = 1'b1; chg_valid = 1'b0; chg_amt = '0; coin_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst chg_ready", {31'd0, chg_ready}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst coins", {29'd0, coin_dollar, coin_quarter, coin_dime}, 32'd0);
    check("rst residue", {22'd0, residue}, 32'd0);
    check("rst coin_cnt", {27'd0, coin_cnt}, 32'd0);
    check("rst fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      model(tbl[i].amt, tbl[i].d, tbl[i].h, tbl[i].stuck, mc, mr, mf, md);
      start_payout(tbl[i].amt, $sformatf("vec%0d", i));
      run_payout(tbl[i].d, tbl[i].h, tbl[i].stuck, 1'b0,
                 tbl[i].cnt, tbl[i].res, tbl[i].flt, tbl[i].dcyc, $sformatf("vec%0d", i));
    end

    // chg_valid held with a wandering amount: only the first IDLE cycle's amount counts.
    @(posedge clk); #1;
    chg_valid = 1'b1; chg_amt = AMT_W'(100);
    @(posedge clk); #1;
    model(100, 0, 0, 0, mc, mr, mf, md);
    run_payout(0, 0, 0, 1'b1, mc, mr, mf, md, "hold_valid1");
    @(posedge clk); #1;
    check("hold_valid idle", {31'd0, chg_ready}, 32'd1);
    chg_amt = AMT_W'(35);
    @(posedge clk); #1;
    chg_valid = 1'b0;
    model(35, 0, 0, 0, mc, mr, mf, md);
    run_payout(0, 0, 0, 1'b0, mc, mr, mf, md, "hold_valid2");

    // Reset while a quarter request is outstanding in a payout of 250.
    start_payout(250, "rst_mid");
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (coin_quarter) found = 1;
      else begin
        coin_ack = coin_dollar | coin_dime;
        @(posedge clk); #1;
      end
    end
    check("rst_mid quarter_seen", {31'd0, found}, 32'd1);
    coin_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid chg_ready", {31'd0, chg_ready}, 32'd1);
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid coins", {29'd0, coin_dollar, coin_quarter, coin_dime}, 32'd0);
    check("rst_mid coin_cnt", {27'd0, coin_cnt}, 32'd0);
    check("rst_mid residue", {22'd0, residue}, 32'd0);
    check("rst_mid fault", {31'd0, fault}, 32'd0);
    no_done = 1;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) no_done = 0;
      @(posedge clk); #1;
    end
    check("rst_mid no_done", {31'd0, no_done}, 32'd1);

    for (int i = 0; i < 20; i++) begin
      amt   = $urandom_range(0, 1023);
      d     = $urandom_range(0, 3);
      h     = $urandom_range(0, 3);
      stuck = ($urandom_range(0, 7) == 0) ? 1 : 0;
      model(amt, d, h, stuck, mc, mr, mf, md);
      start_payout(amt, $sformatf("rnd%0d", i));
      run_payout(d, h, stuck, 1'b0, mc, mr, mf, md, $sformatf("rnd%0d amt%0d", i, amt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
